// File: rtl/fpga_console_pkg.sv
// rtl/fpga_console_pkg.sv - shared types and field positions for the console RX bridge
package fpga_console_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    localparam int CHAR_LSB  = 0;
    localparam int VALID_BIT = 8;
    localparam int SEQ_BIT   = 9;
    localparam int COUNT_LSB = 16;

    localparam logic [7:0] ACK_TAG_DEFAULT = 8'hA5;
    localparam int ACK_TAG_LSB = 8;
    localparam int ACK_TAG_MSB = 15;
    localparam int ACK_SEQ_BIT = 0;

endpackage

// File: rtl/console_char_fifo.sv
// rtl/console_char_fifo.sv - 8-bit synchronous FIFO with flush and registered read data
module console_char_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [7:0]       i_push_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [7:0]       o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_drop
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [7:0]       r_rd_data;
    logic             w_do_push;
    logic             w_do_pop;
    logic [PTR_W-1:0] w_diff;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_diff  = r_wr_ptr - r_rd_ptr;
    assign o_count = CNT_W'(w_diff);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);
    assign o_drop    = i_push && !i_flush && o_full && !w_do_pop;
    assign o_rd_data = r_rd_data;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else if (i_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr  <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/fpga_console_rx_bridge.sv
// rtl/fpga_console_rx_bridge.sv - host-to-firmware console char bridge; echo via FPGA_CONSOLE_ECHO_EN
module fpga_console_rx_bridge
    import fpga_console_pkg::*;
#(
    parameter int         DEPTH   = 64,
    parameter logic [7:0] ACK_TAG = ACK_TAG_DEFAULT,
    parameter int         CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             core_clk,
    input  logic             cptra_rst_b,
    input  logic             host_wr_en,
    input  logic [7:0]       host_wr_char,
    input  logic             host_flush,
    input  logic             host_ovf_clr,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic [31:0]      gen_in_wire,
    input  logic             fw_ack_wr,
    input  logic [31:0]      fw_ack_data,
    output logic             echo_valid,
    output logic [7:0]       echo_char
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_seq;
    logic       r_overflow;
    logic       w_ack_hit;
    logic       w_match;
    logic       w_pop;
    logic       w_drop;
    logic [7:0] w_rd_data;
    logic       w_unused_ack;

    assign w_unused_ack = ^{fw_ack_data[31:16], fw_ack_data[7:1]};
    assign w_ack_hit = fw_ack_wr
                    && (fw_ack_data[ACK_TAG_MSB:ACK_TAG_LSB] == ACK_TAG)
                    && (fw_ack_data[ACK_SEQ_BIT] == r_seq);

    console_char_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .i_clk       (core_clk),
        .i_rst_n     (cptra_rst_b),
        .i_push      (host_wr_en),
        .i_push_data (host_wr_char),
        .i_pop       (w_pop),
        .i_flush     (host_flush),
        .o_rd_data   (w_rd_data),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count),
        .o_drop      (w_drop)
    );

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_match      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (w_ack_hit) begin
                    w_match = 1'b1;
                    if (!fifo_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (host_flush) begin
            w_state_next = IDLE;
            w_pop        = 1'b0;
            w_match      = 1'b0;
        end
    end

    // seq flips once per presentation so a replayed ack cannot release a second char.
    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_seq      <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_seq <= ~r_seq;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (host_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign overflow = r_overflow;

    always_comb begin
        gen_in_wire                    = '0;
        gen_in_wire[CHAR_LSB +: 8]     = w_rd_data;
        gen_in_wire[VALID_BIT]         = (r_state == PRESENT);
        gen_in_wire[SEQ_BIT]           = r_seq;
        gen_in_wire[COUNT_LSB +: 16]   = 16'(fifo_count);
    end

`ifdef FPGA_CONSOLE_ECHO_EN
    logic       r_echo_valid;
    logic [7:0] r_echo_char;

    always_ff @(posedge core_clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            r_echo_valid <= 1'b0;
            r_echo_char  <= '0;
        end else begin
            r_echo_valid <= w_match;
            if (w_match) begin
                r_echo_char <= w_rd_data;
            end
        end
    end

    assign echo_valid = r_echo_valid;
    assign echo_char  = r_echo_char;
`else
    assign echo_valid = 1'b0;
    assign echo_char  = 8'h00;
`endif

endmodule
